// File: rtl/audio_level_meter.sv
// audio_level_meter: per-channel windowed mean/peak magnitude meter with a
// one-deep handshaked result register and sticky overrun flag.
module audio_level_meter #(
  parameter int DATA_W = 8,
  parameter int LOG2_WIN = 8,
  parameter int NUM_CH = 2,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = DATA_W + LOG2_WIN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              audio_enable,
  input  logic [DATA_W-1:0] audio_data,
  input  logic [CH_W-1:0]   audio_ch,
  input  logic              mode,
  input  logic              clear,
  output logic [DATA_W-1:0] level,
  output logic [DATA_W-1:0] level_onehot,
  output logic [CH_W-1:0]   level_ch,
  output logic              level_valid,
  input  logic              level_ready,
  output logic              overrun
);
  typedef enum logic {START, ACCUM} st_e;
  st_e               st_q [NUM_CH];
  st_e               st_d [NUM_CH];
  logic [AW-1:0]     acc_q [NUM_CH];
  logic [AW-1:0]     acc_d [NUM_CH];
  logic [LOG2_WIN-1:0] cnt_q [NUM_CH];
  logic [LOG2_WIN-1:0] cnt_d [NUM_CH];
  logic              md_q [NUM_CH];
  logic              md_d [NUM_CH];
  logic              pv_q, pv_d;
  logic [DATA_W-1:0] pl_q, pl_d;
  logic [CH_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] level_q, level_d, oh_q, oh_d, oh_n;
  logic [CH_W-1:0]   lch_q, lch_d;
  logic              valid_q, valid_d, ovr_q, ovr_d;
  logic [2**CH_W-1:0] ch_mask;
  logic              ch_ok, take, first, last, md_eff, load;
  logic [CH_W-1:0]   ci;
  logic [DATA_W-1:0] mag;
  logic [AW-1:0]     base, acc_new;

  always_comb begin
    st_d = st_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    md_d = md_q;
    ch_mask = '0;
    for (int i = 0; i < 2**CH_W; i++) ch_mask[i] = (i < NUM_CH);
    ch_ok = ch_mask[audio_ch];
    ci = ch_ok ? audio_ch : '0;
    mag = audio_data[DATA_W-1] ? ~audio_data + 1'b1 : audio_data;
    first = (st_q[ci] == START);
    md_eff = first ? mode : md_q[ci];
    base = first ? '0 : acc_q[ci];
    acc_new = md_eff ? ((AW'(mag) > base) ? AW'(mag) : base) : base + AW'(mag);
    last = (cnt_q[ci] == '1);
    take = audio_enable && ch_ok && !clear;
    // completed windows sit one cycle in the pending stage before the output register
    pv_d = take && last;
    pl_d = md_eff ? DATA_W'(acc_new) : DATA_W'(acc_new >> LOG2_WIN);
    pc_d = ci;
    if (take) begin
      st_d[ci] = last ? START : ACCUM;
      acc_d[ci] = last ? '0 : acc_new;
      cnt_d[ci] = cnt_q[ci] + 1'b1;
      md_d[ci] = md_eff;
    end
    oh_n = '0;
    for (int i = 0; i < DATA_W; i++) if (pl_q[i]) oh_n = DATA_W'(1) << i;
    load = pv_q && !clear && (!valid_q || level_ready);
    level_d = load ? pl_q : level_q;
    oh_d = load ? oh_n : oh_q;
    lch_d = load ? pc_q : lch_q;
    valid_d = !clear && (load || (valid_q && !level_ready));
    ovr_d = !clear && (ovr_q || (pv_q && valid_q && !level_ready));
    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_d[i] = START;
        acc_d[i] = '0;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i] <= START;
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
        md_q[i] <= 1'b0;
      end
      pv_q <= 1'b0;
      pl_q <= '0;
      pc_q <= '0;
      level_q <= '0;
      oh_q <= '0;
      lch_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      st_q <= st_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      md_q <= md_d;
      pv_q <= pv_d;
      pl_q <= pl_d;
      pc_q <= pc_d;
      level_q <= level_d;
      oh_q <= oh_d;
      lch_q <= lch_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end

  assign level = level_q;
  assign level_onehot = oh_q;
  assign level_ch = lch_q;
  assign level_valid = valid_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: directed scoreboard bench; expected results are queued
// as windows are fed and popped whenever the meter hands a result over.
module tb_audio_level_meter;
  logic       clk = 0, rst_n = 0, audio_enable = 0, mode = 0, clear = 0, level_ready = 1;
  logic [7:0] audio_data = 0;
  logic       audio_ch = 0;
  logic [7:0] level, level_onehot;
  logic       level_ch, level_valid, overrun;
  logic       en3 = 0;
  logic [1:0] ch3 = 0;
  logic [7:0] d3 = 0;
  logic [7:0] l3, oh3;
  logic [1:0] lc3;
  logic       v3, ov3;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic [7:0] lv; logic [7:0] oh; logic ch;} exp_t;
  exp_t q[$];
  exp_t mo, me;

  audio_level_meter #(.DATA_W(8), .LOG2_WIN(2), .NUM_CH(2)) dut (
    .clk(clk), .rst_n(rst_n), .audio_enable(audio_enable), .audio_data(audio_data),
    .audio_ch(audio_ch), .mode(mode), .clear(clear), .level(level),
    .level_onehot(level_onehot), .level_ch(level_ch), .level_valid(level_valid),
    .level_ready(level_ready), .overrun(overrun));

  // three-channel instance so that an out-of-range index (3) is expressible
  audio_level_meter #(.DATA_W(8), .LOG2_WIN(2), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .audio_enable(en3), .audio_data(d3),
    .audio_ch(ch3), .mode(mode), .clear(clear), .level(l3),
    .level_onehot(oh3), .level_ch(lc3), .level_valid(v3),
    .level_ready(level_ready), .overrun(ov3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic c, input logic [7:0] d, input logic m);
    audio_enable = 1;
    audio_ch = c;
    audio_data = d;
    mode = m;
    tick();
    audio_enable = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n && level_valid && level_ready) begin
      mo = {level, level_onehot, level_ch};
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL sb_extra: observed result %0h, expected no result", mo);
      end else begin
        me = q.pop_front();
        chk("sb_result", mo, me);
      end
    end
  end

  initial begin
    #2;
    chk("rst_level", level, 0);
    chk("rst_onehot", level_onehot, 0);
    chk("rst_ch", level_ch, 0);
    chk("rst_valid", level_valid, 0);
    chk("rst_overrun", overrun, 0);
    tick();
    tick();
    rst_n = 1;
    // ch0 mean window
    smp(0, 8'h10, 0);
    smp(0, 8'hF0, 0);
    smp(0, 8'h20, 0);
    q.push_back(exp_t'{8'h18, 8'h10, 1'b0});
    smp(0, 8'hE0, 0);
    chk("t1_latency", level_valid, 0);
    tick();
    chk("t1_valid", level_valid, 1);
    chk("t1_level", level, 8'h18);
    tick();
    chk("t1_valid_1cyc", level_valid, 0);
    // ch1 peak interleaved with ch0 mean; mode toggles mid-window are ignored
    smp(1, 8'h03, 1);
    smp(0, 8'h04, 0);
    smp(1, 8'h80, 0);
    smp(0, 8'h04, 1);
    smp(1, 8'h05, 0);
    smp(0, 8'h04, 0);
    q.push_back(exp_t'{8'h80, 8'h80, 1'b1});
    smp(1, 8'h07, 0);
    tick();
    chk("t2_level", level, 8'h80);
    chk("t2_ch", level_ch, 1);
    q.push_back(exp_t'{8'h06, 8'h04, 1'b0});
    smp(0, 8'hF4, 0);
    tick();
    chk("t2_ch0_level", level, 8'h06);
    tick();
    // stalled consumer: second result is dropped
    level_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q.push_back(exp_t'{8'h08, 8'h08, 1'b0});
      smp(0, 8'h08, 0);
    end
    for (int i = 0; i < 4; i++) smp(1, 8'hC0, 0);
    tick();
    chk("t3_overrun", overrun, 1);
    chk("t3_valid", level_valid, 1);
    chk("t3_held_level", level, 8'h08);
    chk("t3_held_ch", level_ch, 0);
    level_ready = 1;
    tick();
    chk("t3_valid_fall", level_valid, 0);
    chk("t3_overrun_sticky", overrun, 1);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_overrun", overrun, 0);
    // completion coincides with acceptance
    level_ready = 0;
    q.push_back(exp_t'{8'h20, 8'h20, 1'b1});
    for (int i = 0; i < 4; i++) smp(1, 8'h20, 0);
    tick();
    chk("t4_valid", level_valid, 1);
    for (int i = 0; i < 3; i++) smp(0, 8'h30, 0);
    chk("t4_held", level, 8'h20);
    q.push_back(exp_t'{8'h30, 8'h20, 1'b0});
    smp(0, 8'h30, 0);
    level_ready = 1;
    tick();
    chk("t4_valid_stays", level_valid, 1);
    chk("t4_ch", level_ch, 0);
    chk("t4_level", level, 8'h30);
    chk("t4_no_overrun", overrun, 0);
    tick();
    chk("t4_valid_fall", level_valid, 0);
    // reset mid-window discards the partial sum
    smp(0, 8'h7F, 0);
    smp(0, 8'h7F, 0);
    rst_n = 0;
    #2;
    chk("t5_rst_level", level, 0);
    chk("t5_rst_onehot", level_onehot, 0);
    chk("t5_rst_valid", level_valid, 0);
    tick();
    rst_n = 1;
    q.push_back(exp_t'{8'h04, 8'h04, 1'b0});
    for (int i = 0; i < 4; i++) smp(0, 8'h04, 0);
    tick();
    chk("t5_level", level, 8'h04);
    tick();
    // clear mid-window, with a sample on the clear cycle
    smp(0, 8'h7F, 0);
    smp(0, 8'h7F, 0);
    audio_enable = 1;
    audio_ch = 0;
    audio_data = 8'h7F;
    clear = 1;
    tick();
    clear = 0;
    audio_enable = 0;
    q.push_back(exp_t'{8'h04, 8'h04, 1'b0});
    for (int i = 0; i < 4; i++) smp(0, 8'h04, 0);
    tick();
    chk("t5_clr_level", level, 8'h04);
    tick();
    // out-of-range channel strobes on the three-channel instance
    en3 = 1;
    ch3 = 2'd3;
    d3 = 8'h7F;
    for (int i = 0; i < 4; i++) tick();
    tick();
    chk("t6_no_result", v3, 0);
    for (int i = 0; i < 4; i++) begin
      ch3 = 2'd0;
      d3 = 8'h10;
      tick();
      ch3 = 2'd3;
      d3 = 8'h80;
      tick();
    end
    en3 = 0;
    chk("t6_valid", v3, 1);
    chk("t6_level", l3, 8'h10);
    chk("t6_ch", lc3, 0);
    chk("t6_overrun", ov3, 0);
    chk("t6_main_idle", level_valid, 0);
    tick();
    tick();
    chk("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
